pc_stack_sequencer: RTL and testbench



---
 rtl/pc_stack_pkg.sv | 27 ++
 rtl/pc_stack_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pc_stack_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_stack_pkg.sv
// Shared types for the 6502 PC stack sequencer: command ops, FSM states, default stack page.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_stack_pkg;

    localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;

    typedef enum logic [1:0] {
        JSR = 2'b00,
        RTS = 2'b01,
        INT = 2'b10,
        RTI = 2'b11
    } stack_op_e;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PUSH_PCH  = 4'd1,
        ST_PUSH_PCL  = 4'd2,
        ST_PUSH_P    = 4'd3,
        ST_PULL_P    = 4'd4,
        ST_PULL_PCL  = 4'd5,
        ST_PULL_PCH  = 4'd6,
        ST_PULL_LAST = 4'd7,
        ST_DONE      = 4'd8
    } stack_state_e;

endpackage

// File: rtl/pc_stack_sequencer.sv
// Pushes/pulls the 6502 PC (and P for interrupts) to the page-$01 stack and owns SP.
// Latency: accept to done = JSR 3, INT 4, RTS 4, RTI 5 cycles; ready again the cycle after done.
// Backpressure: cmd_ready only in IDLE; cmd_valid outside IDLE is ignored, nothing is queued.
//
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready/cmd_op/pc_in/status_in command side;
// mem_req/mem_we/mem_addr/mem_wdata/mem_rdata single-port sync stack RAM (read data one cycle late);
// jump/jumpAddr/status_load/status_out/done results; sp stack pointer; stk_err sticky wrap flag.
// Build option: define PC_STACK_WRAP_DET_EN to build the SP wrap detector behind stk_err.
module pc_stack_sequencer
    import pc_stack_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT,
    parameter logic [7:0] SP_RESET   = 8'hFD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] pc_in,
    input  logic [7:0]  status_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        jump,
    output logic [15:0] jumpAddr,
    output logic        status_load,
    output logic [7:0]  status_out,
    output logic        done,
    output logic [7:0]  sp,
    output logic        stk_err
);

    stack_state_e state_q, state_d;
    stack_op_e    op_q;
    logic [15:0]  pc_q;
    logic [7:0]   status_q;
    logic [7:0]   sp_q, sp_d;
    logic [7:0]   lo_q;
    logic [15:0]  jump_addr_q;
    logic [7:0]   status_out_q;
    logic         push, pull;
    logic [7:0]   addr_lo;
    logic         accept;

    assign accept = (state_q == ST_IDLE) && cmd_valid;

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        push        = 1'b0;
        pull        = 1'b0;
        addr_lo     = 8'h00;
        mem_wdata   = 8'h00;
        cmd_ready   = 1'b0;
        done        = 1'b0;
        jump        = 1'b0;
        status_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (stack_op_e'(cmd_op))
                        JSR, INT: state_d = ST_PUSH_PCH;
                        RTS:      state_d = ST_PULL_PCL;
                        default:  state_d = ST_PULL_P;
                    endcase
                end
            end
            ST_PUSH_PCH: begin
                push      = 1'b1;
                mem_wdata = pc_q[15:8];
                state_d   = ST_PUSH_PCL;
            end
            ST_PUSH_PCL: begin
                push      = 1'b1;
                mem_wdata = pc_q[7:0];
                state_d   = (op_q == INT) ? ST_PUSH_P : ST_DONE;
            end
            ST_PUSH_P: begin
                push      = 1'b1;
                mem_wdata = status_q;
                state_d   = ST_DONE;
            end
            ST_PULL_P:    begin pull = 1'b1; state_d = ST_PULL_PCL; end
            ST_PULL_PCL:  begin pull = 1'b1; state_d = ST_PULL_PCH; end
            ST_PULL_PCH:  begin pull = 1'b1; state_d = ST_PULL_LAST; end
            // No access here: only collects the high byte read in PULL_PCH.
            ST_PULL_LAST: state_d = ST_DONE;
            ST_DONE: begin
                done        = 1'b1;
                jump        = (op_q == RTS) || (op_q == RTI);
                status_load = (op_q == RTI);
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // 6502 stack: push writes at SP then decrements; pull pre-increments.
        if (push) begin
            addr_lo = sp_q;
            sp_d    = sp_q - 8'd1;
        end else if (pull) begin
            addr_lo = sp_q + 8'd1;
            sp_d    = sp_q + 8'd1;
        end
    end

    assign mem_req  = push | pull;
    assign mem_we   = push;
    assign mem_addr = mem_req ? {STACK_PAGE, addr_lo} : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= JSR;
            pc_q         <= 16'h0000;
            status_q     <= 8'h00;
            sp_q         <= SP_RESET;
            lo_q         <= 8'h00;
            jump_addr_q  <= 16'h0000;
            status_out_q <= 8'h00;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            if (accept) begin
                op_q     <= stack_op_e'(cmd_op);
                pc_q     <= pc_in;
                status_q <= status_in;
            end
            // Read data lags its request by one cycle, so each byte lands in the next state.
            if (state_q == ST_PULL_PCL) status_out_q <= mem_rdata;
            if (state_q == ST_PULL_PCH) lo_q <= mem_rdata;
            if (state_q == ST_PULL_LAST) begin
                // RTS pushed PC-1 style return address; RTI restores the exact PC.
                jump_addr_q <= {mem_rdata, lo_q} + {15'd0, (op_q == RTS)};
            end
        end
    end

    assign jumpAddr   = jump_addr_q;
    assign status_out = status_out_q;
    assign sp         = sp_q;

`ifdef PC_STACK_WRAP_DET_EN
    logic stk_err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            stk_err_q <= 1'b0;
        end else if ((push && sp_q == 8'h00) || (pull && sp_q == 8'hFF)) begin
            stk_err_q <= 1'b1;
        end
    end
    assign stk_err = stk_err_q;
`else
    assign stk_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Bench for pc_stack_sequencer: command table with expected results, RAM-access scoreboard,
// and hand sequences for reset abort, held cmd_valid and an SP_RESET=00 wrapping instance.
// Latency/backpressure: checked against the table per command.
module tb_pc_stack_sequencer;
    import pc_stack_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] pc_in;
    logic [7:0]  status_in;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        jump, status_load, done, stk_err;
    logic [15:0] jump_addr;
    logic [7:0]  status_out, sp;

    logic        cmd_valid1, cmd_ready1;
    logic [1:0]  cmd_op1;
    logic [15:0] pc_in1;
    logic [7:0]  status_in1;
    logic        mem_req1, mem_we1;
    logic [15:0] mem_addr1;
    logic [7:0]  mem_wdata1;
    logic [7:0]  mem_rdata1;
    logic        jump1, status_load1, done1, stk_err1;
    logic [15:0] jump_addr1;
    logic [7:0]  status_out1, sp1;

    pc_stack_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .pc_in(pc_in), .status_in(status_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .jump(jump),
        .jumpAddr(jump_addr), .status_load(status_load), .status_out(status_out), .done(done),
        .sp(sp), .stk_err(stk_err)
    );

    pc_stack_sequencer #(.STACK_PAGE(8'h01), .SP_RESET(8'h00)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_op(cmd_op1),
        .pc_in(pc_in1), .status_in(status_in1), .mem_req(mem_req1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .jump(jump1),
        .jumpAddr(jump_addr1), .status_load(status_load1), .status_out(status_out1), .done(done1),
        .sp(sp1), .stk_err(stk_err1)
    );
    assign mem_rdata1 = 8'h00;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stack RAM model: synchronous write, read data one cycle after request.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_req && mem_we)  ram[mem_addr[7:0]] <= mem_wdata;
        if (mem_req && !mem_we) mem_rdata <= ram[mem_addr[7:0]];
    end

    // Scoreboard of expected RAM accesses for dut.
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;
    acc_t sb_q[$];
    bit   sb_en;
    logic [7:0] msp;

    always @(negedge clk) begin
        acc_t e;
        if (sb_en && mem_req) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_access", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb_we", {31'd0, mem_we}, {31'd0, e.we});
                check("sb_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                if (e.we) check("sb_wdata", {24'd0, mem_wdata}, {24'd0, e.data});
            end
        end
    end

    // Write log for the SP_RESET=00 instance.
    logic [23:0] log1_q[$];
    always @(negedge clk) begin
        if (mem_req1 && mem_we1) log1_q.push_back({mem_addr1, mem_wdata1});
    end

    task automatic mpush(input logic [7:0] d);
        sb_q.push_back('{1'b1, {8'h01, msp}, d});
        msp = msp - 8'd1;
    endtask

    task automatic mpull();
        msp = msp + 8'd1;
        sb_q.push_back('{1'b0, {8'h01, msp}, 8'h00});
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [15:0] pc, input logic [7:0] st);
        case (op)
            2'b00: begin mpush(pc[15:8]); mpush(pc[7:0]); end
            2'b10: begin mpush(pc[15:8]); mpush(pc[7:0]); mpush(st); end
            2'b01: begin mpull(); mpull(); end
            default: begin mpull(); mpull(); mpull(); end
        endcase
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] pc;
        logic [7:0]  st;
        int          lat;
        logic        jmp;
        logic [15:0] jaddr;
        logic        sload;
        logic [7:0]  sout;
        logic [7:0]  sp;
    } vec_t;
    vec_t vecs[8];

    task automatic run_vec(input int i, input vec_t v);
        int got_lat;
        bit early;
        model_cmd(v.op, v.pc, v.st);
        check($sformatf("v%0d_ready", i), {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = v.op; pc_in = v.pc; status_in = v.st;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        got_lat = -1;
        early = 1'b0;
        for (int k = 1; k <= 12 && got_lat < 0; k++) begin
            if (done) begin
                got_lat = k;
                check($sformatf("v%0d_jump", i), {31'd0, jump}, {31'd0, v.jmp});
                check($sformatf("v%0d_status_load", i), {31'd0, status_load}, {31'd0, v.sload});
                if (v.jmp) check($sformatf("v%0d_jumpAddr", i), {16'd0, jump_addr}, {16'd0, v.jaddr});
                if (v.sload) check($sformatf("v%0d_status_out", i), {24'd0, status_out}, {24'd0, v.sout});
                check($sformatf("v%0d_sp", i), {24'd0, sp}, {24'd0, v.sp});
            end else begin
                if (jump || status_load) early = 1'b1;
                @(posedge clk); #1;
            end
        end
        check($sformatf("v%0d_latency", i), got_lat, v.lat);
        check($sformatf("v%0d_stray_jump", i), {31'd0, early}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d_ready_after", i), {31'd0, cmd_ready}, 32'd1);
        check($sformatf("v%0d_sb_drained", i), sb_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d1, d2;
        bit  j1, seen;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; pc_in = 16'h0; status_in = 8'h0;
        cmd_valid1 = 1'b0; cmd_op1 = 2'b00; pc_in1 = 16'h0; status_in1 = 8'h0;
        sb_en = 1'b1;
        msp = 8'hFD;
        //        op     pc        st     lat jmp   jaddr     sload sout   sp
        vecs[0] = '{JSR, 16'h1234, 8'h00, 3, 1'b0, 16'h0000, 1'b0, 8'h00, 8'hFB};
        vecs[1] = '{RTS, 16'h0000, 8'h00, 4, 1'b1, 16'h1235, 1'b0, 8'h00, 8'hFD};
        vecs[2] = '{INT, 16'hABCD, 8'hA5, 4, 1'b0, 16'h0000, 1'b0, 8'h00, 8'hFA};
        vecs[3] = '{RTI, 16'h0000, 8'h00, 5, 1'b1, 16'hABCD, 1'b1, 8'hA5, 8'hFD};
        vecs[4] = '{JSR, 16'hFFFF, 8'h00, 3, 1'b0, 16'h0000, 1'b0, 8'h00, 8'hFB};
        vecs[5] = '{RTS, 16'h0000, 8'h00, 4, 1'b1, 16'h0000, 1'b0, 8'h00, 8'hFD};
        vecs[6] = '{INT, 16'h0080, 8'h30, 4, 1'b0, 16'h0000, 1'b0, 8'h00, 8'hFA};
        vecs[7] = '{RTI, 16'h0000, 8'h00, 5, 1'b1, 16'h0080, 1'b1, 8'h30, 8'hFD};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_sp", {24'd0, sp}, 32'h0FD);
        check("rst_jumpAddr", {16'd0, jump_addr}, 32'd0);
        check("rst_status_out", {24'd0, status_out}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_done_jump", {30'd0, done, jump}, 32'd0);
        check("rst_stk_err", {31'd0, stk_err}, 32'd0);
        check("rst_sp1", {24'd0, sp1}, 32'd0);
        check("rst_stk_err1", {31'd0, stk_err1}, 32'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset during PULL_PCH of an RTS aborts without jump/done.
        sb_en = 1'b0;
        cmd_valid = 1'b1; cmd_op = RTS;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_mid_sp", {24'd0, sp}, 32'h0FE);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_jump", {31'd0, jump}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sp", {24'd0, sp}, 32'h0FD);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        seen = 1'b0;
        repeat (4) begin
            if (done || jump) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_late_done", {31'd0, seen}, 32'd0);
        sb_q.delete();
        msp = 8'hFD;
        sb_en = 1'b1;

        // cmd_valid held with RTS during a JSR: only JSR runs, RTS accepted after DONE.
        model_cmd(JSR, 16'h4321, 8'h00);
        model_cmd(RTS, 16'h0000, 8'h00);
        cmd_valid = 1'b1; cmd_op = JSR; pc_in = 16'h4321;
        @(posedge clk); #1;
        cmd_op = RTS;
        d1 = -1; d2 = -1; j1 = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (done) begin
                if (d1 < 0) begin
                    d1 = k;
                    j1 = jump;
                end else if (d2 < 0) begin
                    d2 = k;
                    check("hold_rts_jump", {31'd0, jump}, 32'd1);
                    check("hold_rts_jumpAddr", {16'd0, jump_addr}, 32'h4322);
                end
            end
            if (k == 2) check("hold_busy_not_ready", {31'd0, cmd_ready}, 32'd0);
            if (k == 4) check("hold_idle_ready", {31'd0, cmd_ready}, 32'd1);
            if (k == 5) cmd_valid = 1'b0;
            @(posedge clk); #1;
        end
        check("hold_jsr_done_cycle", d1, 32'd3);
        check("hold_jsr_no_jump", {31'd0, j1}, 32'd0);
        check("hold_rts_done_cycle", d2, 32'd8);
        check("hold_sp", {24'd0, sp}, 32'h0FD);
        check("hold_sb_drained", sb_q.size(), 32'd0);
        check("no_wrap_stk_err", {31'd0, stk_err}, 32'd0);

        // SP_RESET=00 instance: JSR wraps SP through 00 -> FF.
        log1_q.delete();
        cmd_valid1 = 1'b1; cmd_op1 = JSR; pc_in1 = 16'h5678;
        @(posedge clk); #1;
        cmd_valid1 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("wrap_write_count", log1_q.size(), 32'd2);
        if (log1_q.size() >= 2) begin
            check("wrap_write0", {8'd0, log1_q[0]}, 32'h0001_0056);
            check("wrap_write1", {8'd0, log1_q[1]}, 32'h0001_FF78);
        end
        check("wrap_sp", {24'd0, sp1}, 32'h0FE);
`ifdef PC_STACK_WRAP_DET_EN
        check("wrap_stk_err", {31'd0, stk_err1}, 32'd1);
`else
        check("wrap_stk_err", {31'd0, stk_err1}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
